output_conditioner: RTL and testbench
=====================================

# output_conditioner

Downstream stage of the function generator. Takes its 14-bit offset-binary waveform every clock, applies amplitude gain and DC offset, saturates the result, and drives the DAC code. Gain and offset changes go through a request/acknowledge handshake. Each change ramps in linearly so the DAC output never steps abruptly. Three-stage pipeline, one sample per clock, no stalls.

## Interface
- GAIN_STEP, 16: maximum change of the active gain per clock while ramping (LSBs of the Q1.15 gain).
- OFFSET_STEP, 4: maximum change of the active offset per clock while ramping (DAC codes).
- RAMP_EN, 1: when 1, use the linear ramp; when 0, load targets directly.

Ports:
- clk  input  1  125 MHz system clock.
- rst  input  1  reset; asynchronous, active-high.
- wave_in  input  14  generator sample; unsigned offset-binary; midscale 8192; valid every clock.
- amplitude  input  16  target gain, unsigned Q1.15 (0x8000 = 1.0, 0xFFFF ≈ 2.0).
- offset  input  16  target DC offset, signed two's complement, in DAC codes.
- update_req  input  1  rising edge requests capture of amplitude/offset.
- busy  output  1  high while a requested update is in progress.
- update_ack  output  1  one-cycle pulse when the active values equal the targets.
- dac_out  output  14  conditioned DAC code.
- clip  output  1  high when the sample on dac_out was saturated; aligned with dac_out.

## Operation
- Pipeline, stage 1: s = wave_in − 8192, signed 15-bit, range −8192..8191.
- Stage 2: p = (s × active_gain) >>> 15.
  - Full 31-bit signed product.
  - Arithmetic shift, truncation toward −∞.
  - Uses active_gain as it is at the stage-2 clock edge.
- Stage 3: r = p + active_offset + 8192, evaluated at 18 bits signed.
  - r < 0 → dac_out = 0, clip = 1.
  - r > 16383 → dac_out = 16383, clip = 1.
  - Otherwise dac_out = r, clip = 0.
- Update FSM has two states, IDLE and RAMP.
  - IDLE: a rising edge of update_req (req vs. registered req_d) captures amplitude/offset into target registers, sets busy, and moves to RAMP.
  - RAMP with RAMP_EN=1, each clock:
    - If active_gain == target_gain and active_offset == target_offset: clear busy, pulse update_ack, go to IDLE.
    - Otherwise move each active value toward its target by min(step, |difference|). No overshoot. Gain and offset ramp independently.
  - RAMP with RAMP_EN=0: first RAMP clock loads active = target; next clock runs the equality check and acks.
- update_req edges seen while busy are ignored; no queuing. amplitude/offset changes outside a capture have no effect.
- Targets equal to the current active values: ack on the first RAMP clock.

## Timing
- Latency wave_in → dac_out/clip: 3 clocks. A sample registered at edge N appears after edge N+3.
- Throughput: 1 sample per clock.
- Handshake: update_req rising edge seen at edge T0.
  - busy = 1 after T0.
  - With RAMP_EN=1 and k = max(ceil(|Δgain|/GAIN_STEP), ceil(|Δoffset|/OFFSET_STEP)): steps occur at T1..Tk; at T(k+1) busy falls and update_ack rises; update_ack falls at T(k+2).
  - With RAMP_EN=0: load at T1; busy falls and ack rises at T2.
- Gain/offset changes reach dac_out 2 and 1 clocks respectively after the active register updates.
- Reset values (asynchronous, immediate):
  - active_gain = 0x8000, active_offset = 0.
  - Targets equal to the active values.
  - req_d = 0, so a req held high through reset release triggers one update.
  - busy = 0, update_ack = 0, clip = 0.
  - All pipeline stages hold midscale, so dac_out = 8192.
- Reset mid-ramp: the ramp is abandoned, values return to their reset defaults, and no ack is issued.

## Test plan
- Reset: assert rst mid-stream → dac_out = 8192, clip = 0, busy = 0 immediately; after release, wave_in = 12000 gives dac_out = 12000 three clocks later.
- Half gain, RAMP_EN=0: amplitude = 0x4000, offset = 0, pulse req; after ack, wave_in = 12000 → dac_out = 10096; wave_in = 4000 → 6096.
- Saturation: gain 0xFFFF. wave_in = 16383 → dac_out 16383, clip 1. wave_in = 0 → 0, clip 1. wave_in = 8192 → 8192, clip 0.
- Offset ramp: offset 0 → +100 with OFFSET_STEP=4, wave_in = 8192; dac_out climbs 4 codes/clock; busy for 26 clocks; single ack pulse at T26; final dac_out = 8292.
- Ignored request: second req edge during a ramp of gain 0x8000 → 0x8100 → target unchanged; exactly one ack at T17.
- Reset during ramp: rst at T5 of a gain ramp → active_gain = 0x8000, busy = 0, no ack; unity passthrough resumes.

Source files
------------

// File: rtl/output_conditioner.sv
// Output conditioner: gain, DC offset and saturation for the 14-bit DAC path,
// with a request/acknowledge update port whose gain/offset changes ramp in linearly.
module output_conditioner #(
    parameter int GAIN_STEP   = 16,
    parameter int OFFSET_STEP = 4,
    parameter bit RAMP_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] wave_in,
    input  logic [15:0] amplitude,
    input  logic [15:0] offset,
    input  logic        update_req,
    output logic        busy,
    output logic        update_ack,
    output logic [13:0] dac_out,
    output logic        clip
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam logic signed [16:0] GAIN_STEP_S   = 17'(GAIN_STEP);
    localparam logic signed [16:0] OFFSET_STEP_S = 17'(OFFSET_STEP);

    state_t             state_q, state_d;
    logic               req_d_q, req_d_d;
    logic        [15:0] gain_q, gain_d;
    logic        [15:0] tgt_gain_q, tgt_gain_d;
    logic signed [15:0] off_q, off_d;
    logic signed [15:0] tgt_off_q, tgt_off_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;

    logic signed [14:0] s_q, s_d;
    logic signed [15:0] p_q, p_d;
    logic        [13:0] dac_q, dac_d;
    logic               clip_q, clip_d;

    logic signed [16:0] gain_diff_s;
    logic signed [16:0] off_diff_s;
    logic signed [30:0] prod_s;
    logic signed [17:0] sum_s;

    // Update handshake: capture targets on a request edge, then walk the active values toward them
    always_comb begin
        state_d     = state_q;
        req_d_d     = update_req;
        gain_d      = gain_q;
        tgt_gain_d  = tgt_gain_q;
        off_d       = off_q;
        tgt_off_d   = tgt_off_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        gain_diff_s = $signed({1'b0, tgt_gain_q}) - $signed({1'b0, gain_q});
        off_diff_s  = $signed({tgt_off_q[15], tgt_off_q}) - $signed({off_q[15], off_q});

        case (state_q)
            ST_IDLE: begin
                if (update_req && !req_d_q) begin
                    tgt_gain_d = amplitude;
                    tgt_off_d  = offset;
                    busy_d     = 1'b1;
                    state_d    = ST_RAMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if ((gain_q == tgt_gain_q) && (off_q == tgt_off_q)) begin
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Direct mode jumps in one clock; otherwise each value moves by at most its step
                    if (RAMP_EN == 1'b0) begin
                        gain_d = tgt_gain_q;
                    end else if (gain_diff_s > GAIN_STEP_S) begin
                        gain_d = gain_q + GAIN_STEP_S[15:0];
                    end else if (gain_diff_s < -GAIN_STEP_S) begin
                        gain_d = gain_q - GAIN_STEP_S[15:0];
                    end else begin
                        gain_d = tgt_gain_q;
                    end

                    if (RAMP_EN == 1'b0) begin
                        off_d = tgt_off_q;
                    end else if (off_diff_s > OFFSET_STEP_S) begin
                        off_d = off_q + OFFSET_STEP_S[15:0];
                    end else if (off_diff_s < -OFFSET_STEP_S) begin
                        off_d = off_q - OFFSET_STEP_S[15:0];
                    end else begin
                        off_d = tgt_off_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: offset-binary to signed, gain multiply, then offset add with saturation
    always_comb begin
        s_d    = {~wave_in[13], ~wave_in[13], wave_in[12:0]};
        prod_s = $signed({{16{s_q[14]}}, s_q}) * $signed({15'd0, gain_q});
        p_d    = 16'(prod_s >>> 15);
        sum_s  = $signed({{2{p_q[15]}}, p_q}) + $signed({{2{off_q[15]}}, off_q}) + 18'sd8192;
        if (sum_s < 18'sd0) begin
            dac_d  = 14'd0;
            clip_d = 1'b1;
        end else if (sum_s > 18'sd16383) begin
            dac_d  = 14'd16383;
            clip_d = 1'b1;
        end else begin
            dac_d  = sum_s[13:0];
            clip_d = 1'b0;
        end
    end

    // State, control and pipeline registers; reset leaves the pipeline at midscale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_d_q    <= 1'b0;
            gain_q     <= 16'h8000;
            tgt_gain_q <= 16'h8000;
            off_q      <= 16'sd0;
            tgt_off_q  <= 16'sd0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            s_q        <= 15'sd0;
            p_q        <= 16'sd0;
            dac_q      <= 14'd8192;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_d_q    <= req_d_d;
            gain_q     <= gain_d;
            tgt_gain_q <= tgt_gain_d;
            off_q      <= off_d;
            tgt_off_q  <= tgt_off_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            s_q        <= s_d;
            p_q        <= p_d;
            dac_q      <= dac_d;
            clip_q     <= clip_d;
        end
    end

    assign busy       = busy_q;
    assign update_ack = ack_q;
    assign dac_out    = dac_q;
    assign clip       = clip_q;

endmodule

// File: tb/tb_output_conditioner.sv
// Bench for output_conditioner: a ramping instance and a direct-load instance share
// stimulus; an integer model checks both every cycle, literal checks pin the model.
module tb_output_conditioner;

    localparam int GS = 16;
    localparam int OS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] wave_in;
    logic [15:0] amplitude;
    logic [15:0] offset;
    logic        update_req;
    logic        busy_r, ack_r, clip_r, busy_d, ack_d, clip_d;
    logic [13:0] dac_r, dac_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #4 clk = ~clk;

    output_conditioner #(.GAIN_STEP(GS), .OFFSET_STEP(OS), .RAMP_EN(1'b1)) dut_r (
        .clk(clk), .rst(rst), .wave_in(wave_in), .amplitude(amplitude), .offset(offset),
        .update_req(update_req), .busy(busy_r), .update_ack(ack_r), .dac_out(dac_r), .clip(clip_r)
    );

    output_conditioner #(.GAIN_STEP(GS), .OFFSET_STEP(OS), .RAMP_EN(1'b0)) dut_d (
        .clk(clk), .rst(rst), .wave_in(wave_in), .amplitude(amplitude), .offset(offset),
        .update_req(update_req), .busy(busy_d), .update_ack(ack_d), .dac_out(dac_d), .clip(clip_d)
    );

    // Model state; index 0 = ramping instance, 1 = direct-load instance
    int m_gain[2], m_off[2], m_tg[2], m_to[2];
    bit m_busy[2], m_ack[2];
    bit m_req_prev;
    int w_h[3];
    int g_h[2][3];
    int o_h[2][3];

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int move_toward(input int cur, input int tgt, input int step, input bit ramp);
        if (!ramp) return tgt;
        if (tgt - cur > step) return cur + step;
        if (cur - tgt > step) return cur - step;
        return tgt;
    endfunction

    function automatic int exp_raw(input int i);
        longint prod;
        prod = longint'(w_h[2] - 8192) * longint'(g_h[i][1]);
        return int'(prod >>> 15) + o_h[i][0] + 8192;
    endfunction

    function automatic int clamp(input int r);
        if (r < 0) return 0;
        if (r > 16383) return 16383;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_gain[i] = 32768; m_tg[i] = 32768;
            m_off[i]  = 0;     m_to[i] = 0;
            m_busy[i] = 1'b0;  m_ack[i] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                g_h[i][k] = 32768;
                o_h[i][k] = 0;
            end
        end
        for (int k = 0; k < 3; k++) w_h[k] = 8192;
        m_req_prev = 1'b0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            g_h[i][2] = g_h[i][1]; g_h[i][1] = g_h[i][0]; g_h[i][0] = m_gain[i];
            o_h[i][2] = o_h[i][1]; o_h[i][1] = o_h[i][0]; o_h[i][0] = m_off[i];
        end
        w_h[2] = w_h[1]; w_h[1] = w_h[0]; w_h[0] = int'(wave_in);
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 1'b0;
            if (!m_busy[i]) begin
                if (update_req && !m_req_prev) begin
                    m_tg[i]   = int'(amplitude);
                    m_to[i]   = int'($signed(offset));
                    m_busy[i] = 1'b1;
                end
            end else if (m_gain[i] == m_tg[i] && m_off[i] == m_to[i]) begin
                m_busy[i] = 1'b0;
                m_ack[i]  = 1'b1;
            end else begin
                m_gain[i] = move_toward(m_gain[i], m_tg[i], GS, i == 0);
                m_off[i]  = move_toward(m_off[i], m_to[i], OS, i == 0);
            end
        end
        m_req_prev = update_req;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    int raw_r, raw_d;
    initial begin
        forever begin
            @(negedge clk);
            raw_r = exp_raw(0);
            raw_d = exp_raw(1);
            chk("cyc dac_r",  int'(dac_r),  clamp(raw_r));
            chk("cyc clip_r", int'(clip_r), (raw_r != clamp(raw_r)) ? 1 : 0);
            chk("cyc busy_r", int'(busy_r), int'(m_busy[0]));
            chk("cyc ack_r",  int'(ack_r),  int'(m_ack[0]));
            chk("cyc dac_d",  int'(dac_d),  clamp(raw_d));
            chk("cyc clip_d", int'(clip_d), (raw_d != clamp(raw_d)) ? 1 : 0);
            chk("cyc busy_d", int'(busy_d), int'(m_busy[1]));
            chk("cyc ack_d",  int'(ack_d),  int'(m_ack[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack_r(input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            tick();
            if (ack_r) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
    endtask

    int busy_cnt, ack_cnt, ack_at;

    initial begin
        rst = 1'b1; wave_in = 14'd8192; amplitude = 16'h8000; offset = 16'h0000; update_req = 1'b0;
        repeat (3) tick();
        chk("reset dac", int'(dac_r), 8192);
        chk("reset clip", int'(clip_r), 0);
        chk("reset busy", int'(busy_r), 0);
        rst = 1'b0;

        // Unity passthrough, then asynchronous reset mid-stream
        wave_in = 14'd12000;
        repeat (3) tick();
        chk("unity passthrough", int'(dac_r), 12000);
        rst = 1'b1;
        #1;
        chk("async reset dac", int'(dac_r), 8192);
        chk("async reset clip", int'(clip_r), 0);
        chk("async reset busy", int'(busy_r), 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("latency 2 clocks still midscale", int'(dac_r), 8192);
        tick();
        chk("latency 3 clocks", int'(dac_r), 12000);

        // Half gain through the direct-load instance
        amplitude = 16'h4000; offset = 16'h0000; update_req = 1'b1;
        tick();
        update_req = 1'b0;
        chk("direct busy at T0", int'(busy_d), 1);
        tick();
        chk("direct no ack at T1", int'(ack_d), 0);
        tick();
        chk("direct ack at T2", int'(ack_d), 1);
        chk("direct busy low at T2", int'(busy_d), 0);
        wave_in = 14'd12000;
        repeat (3) tick();
        chk("half gain 12000", int'(dac_d), 10096);
        wave_in = 14'd4000;
        repeat (3) tick();
        chk("half gain 4000", int'(dac_d), 6096);
        wait_ack_r(1200, "half gain ramp ack timeout");
        tick();
        chk("ramped half gain 4000", int'(dac_r), 6096);

        // Saturation at maximum gain
        amplitude = 16'hFFFF; update_req = 1'b1;
        tick();
        update_req = 1'b0;
        wait_ack_r(3200, "max gain ramp ack timeout");
        tick();
        wave_in = 14'd16383;
        repeat (3) tick();
        chk("sat high dac_r", int'(dac_r), 16383);
        chk("sat high clip_r", int'(clip_r), 1);
        chk("sat high dac_d", int'(dac_d), 16383);
        wave_in = 14'd0;
        repeat (3) tick();
        chk("sat low dac_r", int'(dac_r), 0);
        chk("sat low clip_r", int'(clip_r), 1);
        chk("sat low clip_d", int'(clip_d), 1);
        wave_in = 14'd8192;
        repeat (3) tick();
        chk("midscale dac_r", int'(dac_r), 8192);
        chk("midscale clip_r", int'(clip_r), 0);

        // Offset ramp 0 -> +100 at 4 codes per clock
        offset = 16'd100; update_req = 1'b1;
        tick();
        update_req = 1'b0;
        busy_cnt = busy_r ? 1 : 0;
        ack_cnt = 0; ack_at = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (busy_r) busy_cnt++;
            if (ack_r) begin ack_cnt++; ack_at = t; end
            if (t == 2) chk("offset first step", int'(dac_r), 8196);
        end
        chk("offset ramp busy clocks", busy_cnt, 26);
        chk("offset ramp ack count", ack_cnt, 1);
        chk("offset ramp ack edge", ack_at, 26);
        chk("offset ramp final dac_r", int'(dac_r), 8292);
        chk("offset final dac_d", int'(dac_d), 8292);

        // Second request edge during a gain ramp is ignored
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        wave_in = 14'd12000; amplitude = 16'h8100; offset = 16'h0000; update_req = 1'b1;
        tick();
        ack_cnt = 0; ack_at = 0;
        for (int t = 1; t <= 30; t++) begin
            update_req = (t == 4);
            if (t == 4) begin
                amplitude = 16'h9000;
                offset = 16'd50;
            end
            tick();
            if (ack_r) begin ack_cnt++; ack_at = t; end
        end
        update_req = 1'b0;
        chk("ignored req ack count", ack_cnt, 1);
        chk("ignored req ack edge", ack_at, 17);
        chk("gain 0x8100 on 12000", int'(dac_r), 12029);

        // Reset in the middle of a gain ramp
        amplitude = 16'h8800; offset = 16'h0000; update_req = 1'b1;
        tick();
        update_req = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid-ramp reset busy", int'(busy_r), 0);
        chk("mid-ramp reset ack", int'(ack_r), 0);
        tick();
        rst = 1'b0;
        ack_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (ack_r) ack_cnt++;
        end
        chk("no ack after mid-ramp reset", ack_cnt, 0);
        chk("unity after mid-ramp reset", int'(dac_r), 12000);

        // Request held high through reset release triggers one update, equal targets ack at T1
        rst = 1'b1; amplitude = 16'h8000; offset = 16'h0000; update_req = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        ack_cnt = 0; ack_at = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (ack_r) begin ack_cnt++; ack_at = t; end
        end
        update_req = 1'b0;
        chk("req through reset ack count", ack_cnt, 1);
        chk("req through reset ack edge", ack_at, 2);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
